// File: rtl/synth_clk_pkg.sv
// synth_clk_pkg: shared widths, reset ratios and the ratio record
// for the multi-channel fractional tick generator.
package synth_clk_pkg;

    localparam int N_CH_DEF   = 4;
    localparam int INT_W_DEF  = 12;
    localparam int FRAC_W_DEF = 8;
    localparam int DEF_INT_V  = 24;
    localparam int DEF_FRAC_V = 0;

    typedef struct packed {
        logic [INT_W_DEF-1:0]  div_int;
        logic [FRAC_W_DEF-1:0] div_frac;
    } ratio_t;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/synth_frac_div.sv
// synth_frac_div: one fractional divider channel with a shadow
// ratio that lands on a rising output edge or on resync.
module synth_frac_div
    import synth_clk_pkg::*;
#(
    parameter int INT_W    = INT_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int DEF_INT  = DEF_INT_V,
    parameter int DEF_FRAC = DEF_FRAC_V
) (
    input  logic              OSC_CLK,
    input  logic              reset_reg_N,
    input  logic              en,
    input  logic              resync,
    input  logic              wr_en,
    input  logic [INT_W-1:0]  wr_int,
    input  logic [FRAC_W-1:0] wr_frac,
    output logic              pend,
    output logic              clk_out,
    output logic              tick
);

    localparam int CW = INT_W + 1;

    typedef struct packed {
        logic [INT_W-1:0]  div_int;
        logic [FRAC_W-1:0] div_frac;
    } chan_ratio_t;

    localparam chan_ratio_t DEF_R = '{INT_W'(DEF_INT), FRAC_W'(DEF_FRAC)};

    chan_ratio_t      act;
    chan_ratio_t      sh;
    chan_ratio_t      nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    lim;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]  acc_sum;
    logic             hit;
    logic             rise;
    logic             apply;

    // the ratio in force for the half-period that starts this edge
    always_comb begin
        hit     = en && !resync && (cnt >= lim);
        rise    = hit && !clk_out;
        apply   = pend && (resync || rise);
        nx      = apply ? sh : act;
        acc_sum = {1'b0, acc} + {1'b0, nx.div_frac};
    end

    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            act     <= DEF_R;
            sh      <= DEF_R;
            pend    <= 1'b0;
            cnt     <= CW'(1);
            lim     <= CW'(DEF_INT);
            acc     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (apply) begin
                act <= sh;
            end
            if (wr_en) begin
                sh   <= '{wr_int, wr_frac};
                pend <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
            if (resync || !en) begin
                cnt     <= CW'(1);
                acc     <= '0;
                lim     <= {1'b0, nx.div_int};
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (hit) begin
                cnt     <= CW'(1);
                acc     <= acc_sum[FRAC_W-1:0];
                lim     <= {1'b0, nx.div_int} + CW'(acc_sum[FRAC_W]);
                clk_out <= !clk_out;
                tick    <= !clk_out;
            end else begin
                cnt  <= cnt + CW'(1);
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/synth_tick_gen.sv
// synth_tick_gen: N_CH fractional clock dividers sharing one
// ratio write port and a common resync strobe.
module synth_tick_gen
    import synth_clk_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int INT_W    = INT_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int DEF_INT  = DEF_INT_V,
    parameter int DEF_FRAC = DEF_FRAC_V
) (
    input  logic                    OSC_CLK,
    input  logic                    reset_reg_N,
    input  logic [N_CH-1:0]         ch_en,
    input  logic                    resync,
    input  logic                    wr_valid,
    input  logic [sel_w(N_CH)-1:0]  wr_ch,
    input  logic [INT_W-1:0]        wr_int,
    input  logic [FRAC_W-1:0]       wr_frac,
    output logic                    wr_err,
    output logic [N_CH-1:0]         pend,
    output logic [N_CH-1:0]         clk_out,
    output logic [N_CH-1:0]         tick
);

    logic            wr_ok;
    logic [N_CH-1:0] wr_sel;

    always_comb begin
        wr_ok  = wr_valid && (wr_int != '0) && (int'(wr_ch) < N_CH);
        wr_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_sel[i] = wr_ok && (int'(wr_ch) == i);
        end
    end

    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_valid && !wr_ok;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        synth_frac_div #(
            .INT_W    (INT_W),
            .FRAC_W   (FRAC_W),
            .DEF_INT  (DEF_INT),
            .DEF_FRAC (DEF_FRAC)
        ) u_div (
            .OSC_CLK     (OSC_CLK),
            .reset_reg_N (reset_reg_N),
            .en          (ch_en[g]),
            .resync      (resync),
            .wr_en       (wr_sel[g]),
            .wr_int      (wr_int),
            .wr_frac     (wr_frac),
            .pend        (pend[g]),
            .clk_out     (clk_out[g]),
            .tick        (tick[g])
        );
    end

endmodule

// File: doc/synth_tick_gen.md
SYNTH_TICK_GEN -- requirements
Module: synth_tick_gen

Interface
REQ-001 Parameter N_CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter INT_W, default 12: width of the integer divide field.
REQ-003 Parameter FRAC_W, default 8: width of the fractional divide field.
REQ-004 Parameter DEF_INT, default 24: reset value of every channel's integer ratio; SHALL be nonzero.
REQ-005 Parameter DEF_FRAC, default 0: reset value of every channel's fractional ratio.
REQ-006 OSC_CLK  in  1  sole clock; all logic on its rising edge.
REQ-007 reset_reg_N  in  1  reset, asynchronous, active-low.
REQ-008 ch_en  in  N_CH  per-channel run enable.
REQ-009 resync  in  1  one-cycle pulse; restarts all channels in phase.
REQ-010 wr_valid  in  1  ratio write strobe, accepted in the same cycle.
REQ-011 wr_ch  in  clog2(N_CH) (min 1)  target channel.
REQ-012 wr_int  in  INT_W  new integer half-period, in OSC_CLK cycles.
REQ-013 wr_frac  in  FRAC_W  new fractional half-period, in units of 2^-FRAC_W cycles.
REQ-014 wr_err  out  1  one-cycle pulse, write rejected.
REQ-015 pend  out  N_CH  shadow ratio written but not yet applied.
REQ-016 clk_out  out  N_CH  divided clock, registered, toggles at half-period boundaries.
REQ-017 tick  out  N_CH  one-cycle strobe, high in the same cycle clk_out goes 0->1.

Function
REQ-018 Each channel SHALL hold cnt (INT_W+1 bits), acc (FRAC_W bits), lim (INT_W+1 bits), and active and shadow ratio registers.
REQ-019 Enabled channel, cnt<lim: cnt<=cnt+1.
REQ-020 Enabled channel, cnt>=lim: cnt<=1; clk_out toggles; {carry,acc}<=acc+frac; lim<=int+carry for the next half-period.
REQ-021 Average half-period SHALL equal int+frac/2^FRAC_W cycles; no half-period SHALL differ from int by more than 1 cycle.
REQ-022 When a write is pending, the shadow ratio SHALL be copied to the active ratio only at a 0->1 toggle of clk_out; pend clears in the same cycle.
REQ-023 A write to a channel whose pend is already set SHALL overwrite the shadow (last write wins).
REQ-024 Writes with wr_int==0 or wr_ch>=N_CH SHALL be ignored, with wr_err asserted in the following cycle.
REQ-025 A write and an apply on the same channel in the same cycle: the apply uses the old shadow, the new value is stored, and pend stays set.
REQ-026 ch_en low SHALL force cnt<=1, acc<=0, lim<=active int, clk_out<=0, tick<=0 on the next edge, and SHALL keep pend/shadow.
REQ-027 After ch_en rises, the first 0->1 toggle SHALL occur div_int cycles later (int=1 gives OSC_CLK/2).
REQ-028 On resync, every channel SHALL apply its pending shadow, then set cnt<=1, acc<=0, lim<=new int, clk_out<=0.
REQ-029 resync SHALL take priority over a toggle in the same cycle; disabled channels remain idle.
REQ-030 tick SHALL never be asserted for two consecutive cycles unless int==1.

Reset
REQ-031 On reset assertion, all state SHALL clear immediately:
- clk_out=0, tick=0, wr_err=0, pend=0;
- cnt=1, acc=0;
- active and shadow ratios = DEF_INT/DEF_FRAC;
- lim=DEF_INT.
REQ-032 Reset asserted mid-period SHALL take effect with no partial pulse on tick.
REQ-033 After reset release, operation resumes on the first rising OSC_CLK edge.

Structure
REQ-034 Package synth_clk_pkg SHALL hold default widths, DEF_INT/DEF_FRAC values, and the ratio record typedef {int, frac}.
REQ-035 Sub-module synth_frac_div SHALL implement one channel (counter, accumulator, shadow, apply logic), instantiated N_CH times.
REQ-036 The top level SHALL hold only write decode, error logic, and resync fan-out.

Verification
REQ-037 FRAC_W=8, ch0 int=4 frac=0, enabled: clk_out period 8 cycles, 50% duty, tick every 8 cycles.
REQ-038 int=2 frac=128: half-periods alternate 2,3 (10 cycles per 4 half-periods); int=2 frac=64: 9 cycles per 4 half-periods.
REQ-039 Write int=6 mid-high-phase with old int=3: pend=1 until the next rising toggle; the new high phase is 6 cycles; no half-period below 3.
REQ-040 Run ch0 int=3 and ch1 int=5, pulse resync: both clk_out=0 next cycle and tick rises 3 and 5 cycles later respectively; coincident ticks recur every LCM(6,10)=30 cycles.
REQ-041 Write wr_int=0, then wr_ch=N_CH: wr_err pulses one cycle each, and ratios are unchanged.
REQ-042 Assert reset_reg_N low mid-period: outputs go to 0 immediately; after release, period returns to DEF_INT defaults (48 cycles).
